// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 8 data bits LSB first, optional odd/even parity, one stop bit.
// Shares the transmitter's baud_rate / parity_type encoding so both ends use one configuration.
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_system,
   input  logic       rx_in,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   output logic [7:0] data_out,
   output logic       rx_done,
   output logic       parity_error,
   output logic       frame_error,
   output logic       rx_active
);

   localparam int DIV_2400  = (CLK_FREQ + (OVERSAMPLE * 2400)  / 2) / (OVERSAMPLE * 2400);
   localparam int DIV_4800  = (CLK_FREQ + (OVERSAMPLE * 4800)  / 2) / (OVERSAMPLE * 4800);
   localparam int DIV_9600  = (CLK_FREQ + (OVERSAMPLE * 9600)  / 2) / (OVERSAMPLE * 9600);
   localparam int DIV_19200 = (CLK_FREQ + (OVERSAMPLE * 19200) / 2) / (OVERSAMPLE * 19200);
   localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      FINISH,
      BREAK
   } state_t;

   state_t      state, state_nxt;
   logic        rx_meta_p0, rx_s;
   logic [15:0] tick_cnt;
   logic [15:0] div_q;
   logic [3:0]  s_cnt;
   logic [2:0]  bit_cnt;
   logic [1:0]  par_q;
   logic [7:0]  shift_q;
   logic        par_bad_q;
   logic        stop_q;
   logic        tick;
   logic        mid_pt;
   logic        bit_pt;
   logic        par_en;
   logic        par_exp;
   logic        start_det;
   logic [15:0] div_sel;

   function automatic logic [15:0] baud_div(input logic [1:0] sel);
      case (sel)
         2'b00:   baud_div = 16'(DIV_2400);
         2'b01:   baud_div = 16'(DIV_4800);
         2'b10:   baud_div = 16'(DIV_9600);
         default: baud_div = 16'(DIV_19200);
      endcase
   endfunction

   function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] d);
      parity_bit = (mode == 2'b10) ? (^d) : ~(^d);
   endfunction

   assign div_sel   = baud_div(baud_rate);
   assign tick      = (tick_cnt == div_q - 16'd1);
   // START measures half a bit from the falling edge; later bits are a full bit apart
   assign mid_pt    = tick && (s_cnt == MID_CNT);
   assign bit_pt    = tick && (s_cnt == LAST_CNT);
   assign par_en    = (par_q == 2'b01) || (par_q == 2'b10);
   assign par_exp   = parity_bit(par_q, shift_q);
   assign start_det = (state == IDLE) && !rx_s;

   always_comb begin
      state_nxt = state;
      rx_active = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) state_nxt = START;
         end
         START: begin
            rx_active = 1'b1;
            if (mid_pt) state_nxt = rx_s ? IDLE : DATA;
         end
         DATA: begin
            rx_active = 1'b1;
            if (bit_pt && (bit_cnt == 3'd7)) state_nxt = par_en ? PARITY : STOP;
         end
         PARITY: begin
            rx_active = 1'b1;
            if (bit_pt) state_nxt = STOP;
         end
         STOP: begin
            rx_active = 1'b1;
            if (bit_pt) state_nxt = FINISH;
         end
         FINISH: begin
            rx_active = 1'b1;
            state_nxt = stop_q ? IDLE : BREAK;
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // synchronizer and control state
   always_ff @(posedge clk) begin
      if (!rst_system) begin
         state      <= IDLE;
         rx_meta_p0 <= 1'b1;
         rx_s       <= 1'b1;
         tick_cnt   <= '0;
         s_cnt      <= '0;
         bit_cnt    <= '0;
         div_q      <= 16'(DIV_9600);
         par_q      <= 2'b00;
      end else begin
         state      <= state_nxt;
         rx_meta_p0 <= rx_in;
         rx_s       <= rx_meta_p0;

         if (state == IDLE || tick) tick_cnt <= '0;
         else                       tick_cnt <= tick_cnt + 16'd1;

         if (state == IDLE || (state == START && mid_pt)) s_cnt <= '0;
         else if (tick)                                    s_cnt <= s_cnt + 4'd1;

         if (state == IDLE)              bit_cnt <= '0;
         else if (state == DATA && bit_pt) bit_cnt <= bit_cnt + 3'd1;

         // configuration is frozen for the whole frame
         if (start_det) begin
            div_q <= div_sel;
            par_q <= parity_type;
         end
      end
   end

   // bit capture
   always_ff @(posedge clk) begin
      if (state == DATA && bit_pt)   shift_q   <= {rx_s, shift_q[7:1]};
      if (state == PARITY && bit_pt) par_bad_q <= rx_s ^ par_exp;
      if (state == STOP && bit_pt)   stop_q    <= rx_s;
   end

   // frame result
   always_ff @(posedge clk) begin
      if (!rst_system) begin
         data_out     <= '0;
         rx_done      <= 1'b0;
         parity_error <= 1'b0;
         frame_error  <= 1'b0;
      end else begin
         rx_done <= (state == FINISH);
         if (state == FINISH) begin
            data_out     <= shift_q;
            parity_error <= par_en & par_bad_q;
            frame_error  <= ~stop_q;
         end
      end
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the downstream stage of the UART transmitter (uart_top), consuming its serial frame output.
- Samples the idle-high line at 16x oversampling and recovers start, 8 data bits (LSB first), optional parity and stop.
- Presents the byte with a one-cycle done pulse and error flags.
- Uses the transmitter's baud_rate/parity_type encoding so both ends share one configuration.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- OVERSAMPLE, 16, ticks per bit; fixed at 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_system  in  1  synchronous, active-low reset.
- rx_in  in  1  serial line, idle high, asynchronous to clk.
- parity_type  in  2  00 none, 01 odd, 10 even, 11 none.
- baud_rate  in  2  00 2400, 01 4800, 10 9600, 11 19200.
- data_out  out  8  last received byte.
- rx_done  out  1  one-cycle pulse on frame completion.
- parity_error  out  1  parity mismatch on last frame.
- frame_error  out  1  stop bit sampled 0 on last frame.
- rx_active  out  1  high while a frame is being received.

Behaviour:
- Reset (rst_system=0 at clk edge):
  - All outputs go to 0. FSM goes to IDLE. Counters clear. Synchronizer flops go to 1.
  - Reset mid-frame abandons the frame with no rx_done.
- Input synchronization:
  - rx_in passes through a 2-flop synchronizer; all logic uses the synchronized rx_s.
  - Edge-to-detect latency is 2 cycles.
- Tick generator:
  - Divisor DIV = round(CLK_FREQ/(16*baud)). At defaults: 1302, 651, 326, 163.
  - The tick counter runs 0..DIV-1 and produces a one-cycle tick at DIV-1.
  - It is cleared on start detection so that sample phase aligns to the falling edge.
- Frame configuration:
  - baud_rate and parity_type are latched at start detection.
  - Changes during a frame are ignored.
- FSM:
  - IDLE: rx_active=0. When rx_s=0, latch config, clear counters, go to START.
  - START: at sample count 7 (mid-bit):
    - rx_s=1 is a false start; return to IDLE with no flags changed.
    - rx_s=0 means reset the sample count and go to DATA.
  - DATA: sample at count 7 of each bit and shift in LSB first. After bit 7, go to PARITY if parity is enabled, else STOP.
  - PARITY: sample at mid-bit.
    - Even: expected bit = XOR of the data bits.
    - Odd: expected bit = its inverse.
    - Store the mismatch.
  - STOP: sample at mid-bit, then in the next cycle:
    - data_out is updated.
    - parity_error is updated (0 when parity is disabled).
    - frame_error = ~stop sample.
    - rx_done=1 for exactly one cycle.
    - Go to IDLE if stop=1, else go to BREAK.
  - BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- rx_active is 1 in START, DATA, PARITY and STOP; 0 in IDLE and BREAK.
- Output holding:
  - data_out, parity_error and frame_error hold until the next completed frame.
  - They are not cleared by a false start.
- Back-to-back frames:
  - Completion at mid-stop returns to IDLE about 8 ticks early, so a start bit immediately after stop is caught.
- Bit period accuracy: DIV rounding error is below 0.2% at all rates. The receiver tolerates ±3% baud mismatch.

Test Plan:
- 9600 baud, even parity, byte 0xA5 serialized at 104.17 us/bit (line: 0, 1,0,1,0,0,1,0,1, parity 0, 1) -> one rx_done pulse, data_out=0xA5, parity_error=0, frame_error=0, rx_active high about 10.5 bit times.
- 19200 baud, odd parity, 0x3C sent with parity bit 0 (correct bit is 1) -> rx_done, data_out=0x3C, parity_error=1.
- 2400 baud, no parity: rx_in low for 100 us (below half-bit of 208 us), then high -> no rx_done, rx_active returns to 0, outputs unchanged.
- 4800 baud, 0x00 with stop bit 0 and line held low 2 ms -> rx_done, frame_error=1, data_out=0x00; no second rx_done until rx_in is high and then falls again.
- Reset asserted at data bit 4 of a 9600 baud frame -> all outputs 0 on the next edge; the next clean frame 0x5A is received correctly.
- Loopback from uart_top at each of the 4 baud_rate × 3 parity settings, 10 random bytes back-to-back -> every byte matches, 10 rx_done pulses, no errors.
